// File: rtl/pattern_stream_gen.sv
// Transmit end of the serial pattern link: a small word FIFO feeding an
// MSB-first serializer with optional idle gap between words and an enable stall.
module pattern_stream_gen #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int GAP   = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           i_word_in,
   input  logic                       i_word_valid,
   output logic                       o_word_ready,
   input  logic                       i_enable,
   output logic                       o_data_out,
   output logic                       o_out_valid,
   output logic                       o_frame_start,
   output logic                       o_busy,
   output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = 4;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_sh;
   logic [BW-1:0]    r_bc;
   logic [GW-1:0]    r_gap;
   logic             r_data_out;
   logic             r_out_valid;
   logic             r_frame_start;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_head;
   logic             w_can_pop;
   logic             w_push;
   logic             w_load;
   logic [BW-1:0]    w_bc_next;
   logic [GW-1:0]    w_gap_next;
   logic             w_data_next;
   logic             w_valid_next;

   assign w_head       = r_mem[r_rd_ptr];
   assign w_can_pop    = (r_count != '0);
   assign o_word_ready = (r_count < CW'(DEPTH));
   assign w_push       = i_word_valid && o_word_ready;

   // r_bc is the index of the bit currently on the line; with enable low
   // everything except the FIFO write side holds its value.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_bc_next    = r_bc;
      w_gap_next   = r_gap;
      w_data_next  = r_data_out;
      w_valid_next = 1'b0;
      if (i_enable) begin
         case (r_state)
            S_IDLE: w_load = w_can_pop;
            S_SHIFT: begin
               if (r_bc != '0) begin
                  w_bc_next    = r_bc - 1'b1;
                  w_data_next  = r_sh[r_bc - 1'b1];
                  w_valid_next = 1'b1;
               end else if (GAP > 0) begin
                  w_state_next = S_GAP;
                  w_gap_next   = GW'(GAP - 1);
               end else begin
                  w_state_next = S_IDLE;
                  w_load       = w_can_pop;
               end
            end
            S_GAP: begin
               if (r_gap != '0) begin
                  w_gap_next = r_gap - 1'b1;
               end else begin
                  w_state_next = S_IDLE;
                  w_load       = w_can_pop;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
         if (w_load) begin
            w_state_next = S_SHIFT;
            w_bc_next    = BW'(WIDTH - 1);
            w_data_next  = w_head[WIDTH-1];
            w_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_word_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_sh          <= '0;
         r_bc          <= '0;
         r_gap         <= '0;
         r_data_out    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_bc          <= w_bc_next;
         r_gap         <= w_gap_next;
         r_data_out    <= w_data_next;
         r_out_valid   <= w_valid_next;
         r_frame_start <= w_load;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_sh     <= w_head;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_load);
      end
   end

   assign o_data_out    = r_data_out;
   assign o_out_valid   = r_out_valid;
   assign o_frame_start = r_frame_start;
   assign o_fifo_count  = r_count;
   assign o_busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule
